dest_decode_scoreboard: RTL and testbench
=========================================

DEST_DECODE_SCOREBOARD -- requirements
Module: dest_decode_scoreboard

Interface
REQ-001 Parameter ADDR_W, default 3, SHALL set the width of every register-address input (range 1..6).
REQ-002 Parameter NUM, default 2**ADDR_W, SHALL be derived, not overridden, and give the number of tracked destinations.
REQ-003 Port clk, input, 1, SHALL be the single rising-edge clock.
REQ-004 Port rst_n, input, 1, SHALL be the reset: asynchronous and active-low.
REQ-005 Port issue_en, input, 1, SHALL request a new pending write to issue_addr.
REQ-006 Port issue_addr, input, ADDR_W, SHALL be the destination of the issuing instruction.
REQ-007 Port wb_en, input, 1, SHALL signal a completed writeback to wb_addr.
REQ-008 Port wb_addr, input, ADDR_W, SHALL be the destination being written back.
REQ-009 Ports src_a_addr and src_b_addr, input, ADDR_W each, SHALL be the source operands of the issuing instruction.
REQ-010 Port src_a_use and src_b_use, input, 1 each, SHALL qualify each source for hazard checking.
REQ-011 Port stall, output, 1, SHALL indicate a combinational hazard: RAW on a used source, or WAW on issue_addr.
REQ-012 Port wr_onehot, output, NUM, SHALL be the registered one-hot decode of the last accepted issue_addr, bit i set when issue_addr==i.
REQ-013 Port pending, output, NUM, SHALL be the registered pending-write bitmap.
REQ-014 Port pend_cnt, output, ADDR_W+1, SHALL be the registered popcount of pending.
REQ-015 Port wb_err, output, 1, SHALL be a sticky flag set by a writeback to a non-pending destination.

Function
REQ-016 The block SHALL accept an issue only when issue_en=1 and stall=0 in the same cycle; accepted = issue_en & ~stall.
REQ-017 stall SHALL be (src_a_use & pending[src_a_addr]) | (src_b_use & pending[src_b_addr]) | (issue_en & pending[issue_addr]), evaluated on current registered pending, with no writeback bypass.
REQ-018 On accept, pending[issue_addr] SHALL be set at the next edge, and wr_onehot SHALL load the decode with 1-cycle latency.
REQ-019 When no issue is accepted, wr_onehot SHALL be all-zero at the next edge; it is a one-cycle pulse per accept.
REQ-020 On wb_en with pending[wb_addr]=1, pending[wb_addr] SHALL clear at the next edge.
REQ-021 On wb_en with pending[wb_addr]=0, pending SHALL be unchanged and wb_err SHALL set and remain set until reset.
REQ-022 For a simultaneous accept and writeback to different addresses, both updates SHALL apply in the same edge.
REQ-023 For a simultaneous writeback and issue to the same address, stall SHALL assert (WAW), no issue is accepted, and the writeback SHALL still clear the bit.
REQ-024 pend_cnt SHALL equal popcount(pending) every cycle, and its maximum value SHALL be NUM without wrap.
REQ-025 Address inputs SHALL be ignored when their enable or use bit is 0.

Reset
REQ-026 While rst_n=0, pending, wr_onehot, pend_cnt and wb_err SHALL be 0 immediately, independent of clk.
REQ-027 Reset asserted mid-operation SHALL discard all pending state, and the first edge after deassertion SHALL behave as from an empty scoreboard.

Structure
REQ-028 A shared package dds_pkg SHALL hold the ADDR_W default and a function deriving NUM.
REQ-029 One sub-module, decoder_n (parametrised ADDR_W-to-2**ADDR_W one-hot decoder with enable), SHALL be instantiated for the issue path and the writeback path.
REQ-030 Hazard lookup SHALL use indexed selection of pending and SHALL NOT use a third decoder.

Verification
REQ-031 Reset then issue addr 5 with no sources -> next cycle wr_onehot=8'b0010_0000, pending[5]=1, pend_cnt=1.
REQ-032 pending[5]=1, src_a_addr=5, src_a_use=1, issue_en=1 -> stall=1, and pending is unchanged after the edge.
REQ-033 pending[3]=1, wb_en addr 3 and issue addr 6 in the same cycle -> pending[3]=0, pending[6]=1, pend_cnt unchanged.
REQ-034 wb_en addr 2 with pending[2]=0 -> wb_err=1 and stays 1 across 10 cycles of idle.
REQ-035 Issue all 8 addresses over 8 cycles -> pend_cnt=8, then an issue to any address stalls; asserting rst_n=0 mid-sequence -> all outputs 0 without a clock edge.
REQ-036 Bench SHALL repeat REQ-031 to REQ-034 with ADDR_W=4, using addr 15 as the boundary case.

Source files
------------

// File: rtl/dds_pkg.sv
// rtl/dds_pkg.sv - shared sizing for the destination scoreboard
package dds_pkg;

   localparam int ADDR_W_DEF = 3;

   function automatic int dds_num(input int addr_w);
      return 1 << addr_w;
   endfunction

endpackage

// File: rtl/dest_decode_scoreboard_decoder.sv
// rtl/dest_decode_scoreboard_decoder.sv - ADDR_W-to-2**ADDR_W one-hot decoder with enable
module decoder_n #(
   parameter int ADDR_W = 3
) (
   input  logic                     en,
   input  logic [ADDR_W-1:0]        addr,
   output logic [(1<<ADDR_W)-1:0]   onehot
);

   always_comb begin
      onehot = '0;
      if (en) onehot[addr] = 1'b1;
   end

endmodule

// File: rtl/dest_decode_scoreboard.sv
// rtl/dest_decode_scoreboard.sv - pending-write scoreboard with RAW/WAW stall and one-hot issue decode
module dest_decode_scoreboard
   import dds_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                issue_en,
   input  logic [ADDR_W-1:0]   issue_addr,
   input  logic                wb_en,
   input  logic [ADDR_W-1:0]   wb_addr,
   input  logic [ADDR_W-1:0]   src_a_addr,
   input  logic [ADDR_W-1:0]   src_b_addr,
   input  logic                src_a_use,
   input  logic                src_b_use,
   output logic                stall,
   output logic [dds_num(ADDR_W)-1:0] wr_onehot,
   output logic [dds_num(ADDR_W)-1:0] pending,
   output logic [ADDR_W:0]     pend_cnt,
   output logic                wb_err
);

   localparam int NUM = dds_num(ADDR_W);

   logic             accepted;
   logic             wb_miss;
   logic [NUM-1:0]   iss_oh;
   logic [NUM-1:0]   wb_oh;
   logic [NUM-1:0]   pending_next;
   logic [ADDR_W:0]  cnt_next;

   // Hazards look only at registered pending; a same-cycle writeback does not unblock.
   assign stall = (src_a_use & pending[src_a_addr])
                | (src_b_use & pending[src_b_addr])
                | (issue_en  & pending[issue_addr]);

   assign accepted = issue_en & ~stall;
   assign wb_miss  = wb_en & ~pending[wb_addr];

   decoder_n #(.ADDR_W(ADDR_W)) u_issue_dec (
      .en     (accepted),
      .addr   (issue_addr),
      .onehot (iss_oh)
   );

   decoder_n #(.ADDR_W(ADDR_W)) u_wb_dec (
      .en     (wb_en),
      .addr   (wb_addr),
      .onehot (wb_oh)
   );

   // Clearing a bit that is already 0 is harmless, so a missed writeback leaves pending intact.
   always_comb begin
      pending_next = (pending & ~wb_oh) | iss_oh;
      cnt_next     = '0;
      for (int i = 0; i < NUM; i++) begin
         cnt_next = cnt_next + {{ADDR_W{1'b0}}, pending_next[i]};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending   <= '0;
         wr_onehot <= '0;
         pend_cnt  <= '0;
         wb_err    <= 1'b0;
      end else begin
         pending   <= pending_next;
         wr_onehot <= iss_oh;
         pend_cnt  <= cnt_next;
         wb_err    <= wb_err | wb_miss;
      end
   end

endmodule

// File: tb/tb_dest_decode_scoreboard.sv
// tb/tb_dest_decode_scoreboard.sv - directed self-checking bench for both 3- and 4-bit address builds
module tb_dest_decode_scoreboard;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic       a_issue_en, a_wb_en, a_src_a_use, a_src_b_use;
   logic [2:0] a_issue_addr, a_wb_addr, a_src_a_addr, a_src_b_addr;
   logic       a_stall, a_wb_err;
   logic [7:0] a_wr_onehot, a_pending;
   logic [3:0] a_pend_cnt;

   logic        b_issue_en, b_wb_en, b_src_a_use, b_src_b_use;
   logic [3:0]  b_issue_addr, b_wb_addr, b_src_a_addr, b_src_b_addr;
   logic        b_stall, b_wb_err;
   logic [15:0] b_wr_onehot, b_pending;
   logic [4:0]  b_pend_cnt;

   int n_pass = 0;
   int n_total = 0;

   dest_decode_scoreboard #(.ADDR_W(3)) dut_a (
      .clk(clk), .rst_n(rst_n),
      .issue_en(a_issue_en), .issue_addr(a_issue_addr),
      .wb_en(a_wb_en), .wb_addr(a_wb_addr),
      .src_a_addr(a_src_a_addr), .src_b_addr(a_src_b_addr),
      .src_a_use(a_src_a_use), .src_b_use(a_src_b_use),
      .stall(a_stall), .wr_onehot(a_wr_onehot), .pending(a_pending),
      .pend_cnt(a_pend_cnt), .wb_err(a_wb_err)
   );

   dest_decode_scoreboard #(.ADDR_W(4)) dut_b (
      .clk(clk), .rst_n(rst_n),
      .issue_en(b_issue_en), .issue_addr(b_issue_addr),
      .wb_en(b_wb_en), .wb_addr(b_wb_addr),
      .src_a_addr(b_src_a_addr), .src_b_addr(b_src_b_addr),
      .src_a_use(b_src_a_use), .src_b_use(b_src_b_use),
      .stall(b_stall), .wr_onehot(b_wr_onehot), .pending(b_pending),
      .pend_cnt(b_pend_cnt), .wb_err(b_wb_err)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_a();
      a_issue_en = 0; a_issue_addr = 0; a_wb_en = 0; a_wb_addr = 0;
      a_src_a_use = 0; a_src_a_addr = 0; a_src_b_use = 0; a_src_b_addr = 0;
   endtask

   task automatic idle_b();
      b_issue_en = 0; b_issue_addr = 0; b_wb_en = 0; b_wb_addr = 0;
      b_src_a_use = 0; b_src_a_addr = 0; b_src_b_use = 0; b_src_b_addr = 0;
   endtask

   initial begin
      idle_a();
      idle_b();
      #2;
      chk("a_rst_pending", a_pending, 0);
      chk("a_rst_onehot",  a_wr_onehot, 0);
      chk("a_rst_cnt",     a_pend_cnt, 0);
      chk("a_rst_wberr",   a_wb_err, 0);
      chk("a_rst_stall",   a_stall, 0);
      chk("b_rst_pending", b_pending, 0);
      chk("b_rst_wberr",   b_wb_err, 0);
      #10 rst_n = 1'b1;
      tick();

      // ---------------- ADDR_W = 3 ----------------
      a_issue_en = 1; a_issue_addr = 5;
      tick(); idle_a();
      chk("a_iss5_onehot",  a_wr_onehot, 32'h20);
      chk("a_iss5_pending", a_pending, 32'h20);
      chk("a_iss5_cnt",     a_pend_cnt, 1);
      tick();
      chk("a_onehot_pulse", a_wr_onehot, 0);

      a_src_a_use = 1; a_src_a_addr = 5; a_issue_en = 1; a_issue_addr = 0;
      #1 chk("a_raw_stall", a_stall, 1);
      tick(); idle_a();
      chk("a_raw_pending", a_pending, 32'h20);
      chk("a_raw_onehot",  a_wr_onehot, 0);

      a_src_a_use = 0; a_src_a_addr = 5; a_issue_en = 0; a_issue_addr = 5;
      #1 chk("a_ignore_addr_stall", a_stall, 0);
      idle_a();

      a_issue_en = 1; a_issue_addr = 3;
      tick(); idle_a();
      chk("a_iss3_pending", a_pending, 32'h28);
      chk("a_iss3_cnt",     a_pend_cnt, 2);

      a_wb_en = 1; a_wb_addr = 3; a_issue_en = 1; a_issue_addr = 6;
      #1 chk("a_wb_iss_nostall", a_stall, 0);
      tick(); idle_a();
      chk("a_wb_iss_pending", a_pending, 32'h60);
      chk("a_wb_iss_cnt",     a_pend_cnt, 2);
      chk("a_wb_iss_onehot",  a_wr_onehot, 32'h40);
      chk("a_wb_iss_wberr",   a_wb_err, 0);

      a_wb_en = 1; a_wb_addr = 2;
      tick(); idle_a();
      chk("a_wberr_set",     a_wb_err, 1);
      chk("a_wberr_pending", a_pending, 32'h60);
      repeat (10) tick();
      chk("a_wberr_sticky", a_wb_err, 1);

      a_issue_en = 1; a_issue_addr = 5; a_wb_en = 1; a_wb_addr = 5;
      #1 chk("a_waw_stall", a_stall, 1);
      tick(); idle_a();
      chk("a_waw_pending", a_pending, 32'h40);
      chk("a_waw_onehot",  a_wr_onehot, 0);
      chk("a_waw_cnt",     a_pend_cnt, 1);

      a_wb_en = 1; a_wb_addr = 6;
      tick(); idle_a();
      chk("a_empty_pending", a_pending, 0);

      for (int i = 0; i < 8; i++) begin
         a_issue_en = 1; a_issue_addr = 3'(i);
         tick();
      end
      idle_a();
      chk("a_full_pending", a_pending, 32'hff);
      chk("a_full_cnt",     a_pend_cnt, 8);
      a_issue_en = 1; a_issue_addr = 2;
      #1 chk("a_full_stall", a_stall, 1);

      #2 rst_n = 1'b0;
      #1;
      chk("a_async_pending", a_pending, 0);
      chk("a_async_onehot",  a_wr_onehot, 0);
      chk("a_async_cnt",     a_pend_cnt, 0);
      chk("a_async_wberr",   a_wb_err, 0);
      idle_a();
      tick();
      rst_n = 1'b1;
      a_issue_en = 1; a_issue_addr = 1;
      tick(); idle_a();
      chk("a_post_rst_pending", a_pending, 32'h02);
      chk("a_post_rst_cnt",     a_pend_cnt, 1);

      // ---------------- ADDR_W = 4 ----------------
      b_issue_en = 1; b_issue_addr = 15;
      tick(); idle_b();
      chk("b_iss15_onehot",  b_wr_onehot, 32'h8000);
      chk("b_iss15_pending", b_pending, 32'h8000);
      chk("b_iss15_cnt",     b_pend_cnt, 1);

      b_src_b_use = 1; b_src_b_addr = 15; b_issue_en = 1; b_issue_addr = 0;
      #1 chk("b_raw_stall", b_stall, 1);
      tick(); idle_b();
      chk("b_raw_pending", b_pending, 32'h8000);

      b_issue_en = 1; b_issue_addr = 3;
      tick(); idle_b();
      b_wb_en = 1; b_wb_addr = 3; b_issue_en = 1; b_issue_addr = 14;
      tick(); idle_b();
      chk("b_wb_iss_pending", b_pending, 32'hc000);
      chk("b_wb_iss_cnt",     b_pend_cnt, 2);

      b_wb_en = 1; b_wb_addr = 2;
      tick(); idle_b();
      chk("b_wberr_set", b_wb_err, 1);
      repeat (10) tick();
      chk("b_wberr_sticky", b_wb_err, 1);
      chk("b_wberr_pending", b_pending, 32'hc000);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
